mc_pc_ir_regs: RTL

- Architectural register stage of the multicycle MIPS datapath: PC, IR, MDR, A/B operand registers and ALUOut.
- Consumes the main controller FSM outputs (IRWrite, PCWrite, Branch, PCSrc) and feeds the decoded opcode back to it.
- Also provides a fetch counter and a sticky misaligned-PC error for the UVM bench.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/flopenr.sv | 18 +
 rtl/mc_pc_ir_regs.sv | 87 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: PC source selects,
// opcodes and the default reset PC.
package mips_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned PSRC_W = 2;

   localparam logic [PSRC_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [PSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [PSRC_W-1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-high reset to a parameterised value.
module flopenr #(
   parameter int unsigned   W       = 32,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/mc_pc_ir_regs.sv
// Multicycle MIPS architectural register stage: PC, IR, MDR, A/B, ALUOut,
// plus a fetch counter and a sticky misaligned-PC-write flag.
module mc_pc_ir_regs
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IRWrite,
   input  logic             PCWrite,
   input  logic             Branch,
   input  logic [1:0]       PCSrc,
   input  logic             zero,
   input  logic [31:0]      alu_result,
   input  logic [31:0]      mem_rdata,
   input  logic [31:0]      rd1,
   input  logic [31:0]      rd2,
   output logic [31:0]      pc,
   output logic [31:0]      instr,
   output logic [5:0]       opcode,
   output logic [31:0]      mdr,
   output logic [31:0]      a_reg,
   output logic [31:0]      b_reg,
   output logic [31:0]      alu_out,
   output logic [CNT_W-1:0] fetch_count,
   output logic             misalign_err
);

   logic [31:0]      pc_q, pc_d, instr_q;
   logic [31:0]      mdr_q, a_q, b_q, alu_out_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             pc_en, pc_we, misalign;

   // Next-PC select and write qualification; a misaligned target never lands in pc
   always_comb begin
      pc_d = pc_q;
      unique case (PCSrc)
         PCSRC_ALU:    pc_d = alu_result;
         PCSRC_ALUOUT: pc_d = alu_out_q;
         PCSRC_JUMP:   pc_d = {pc_q[31:28], instr_q[25:0], 2'b00};
         default:      pc_d = pc_q;
      endcase
      pc_en    = PCWrite | (Branch & zero);
      misalign = pc_en & (pc_d[1:0] != 2'b00);
      pc_we    = pc_en & ~misalign;
      cnt_d    = cnt_q + CNT_W'(1);
      err_d    = err_q | misalign;
   end

   flopenr #(.W(32), .RST_VAL(RESET_PC)) u_pc (
      .clk(clk), .reset(reset), .en(pc_we), .d(pc_d), .q(pc_q));

   flopenr #(.W(32), .RST_VAL(32'h0)) u_ir (
      .clk(clk), .reset(reset), .en(IRWrite), .d(mem_rdata), .q(instr_q));

   flopenr #(.W(32), .RST_VAL(32'h0)) u_mdr (
      .clk(clk), .reset(reset), .en(1'b1), .d(mem_rdata), .q(mdr_q));

   flopenr #(.W(32), .RST_VAL(32'h0)) u_a (
      .clk(clk), .reset(reset), .en(1'b1), .d(rd1), .q(a_q));

   flopenr #(.W(32), .RST_VAL(32'h0)) u_b (
      .clk(clk), .reset(reset), .en(1'b1), .d(rd2), .q(b_q));

   flopenr #(.W(32), .RST_VAL(32'h0)) u_alu_out (
      .clk(clk), .reset(reset), .en(1'b1), .d(alu_result), .q(alu_out_q));

   flopenr #(.W(CNT_W), .RST_VAL('0)) u_fetch_cnt (
      .clk(clk), .reset(reset), .en(IRWrite), .d(cnt_d), .q(cnt_q));

   flopenr #(.W(1), .RST_VAL(1'b0)) u_misalign (
      .clk(clk), .reset(reset), .en(1'b1), .d(err_d), .q(err_q));

   assign pc           = pc_q;
   assign instr        = instr_q;
   assign opcode       = instr_q[31:26];
   assign mdr          = mdr_q;
   assign a_reg        = a_q;
   assign b_reg        = b_q;
   assign alu_out      = alu_out_q;
   assign fetch_count  = cnt_q;
   assign misalign_err = err_q;

endmodule
